channel_arbiter: RTL

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

---
 rtl/channel_arbiter_pkg.sv | 29 ++
 rtl/channel_arbiter_priority_select.sv | 29 ++
 rtl/channel_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/channel_arbiter_pkg.sv
// rtl/channel_arbiter_pkg.sv - shared types, defaults and helpers for the channel arbiter
package channel_arbiter_pkg;

  localparam int NUM_CHANNELS_DEFAULT    = 32;
  localparam int MAX_BURST_BEATS_DEFAULT = 16;

  localparam int CH_ID_W = 5;
  localparam int PRIO_W  = 4;
  localparam int SIZE_W  = 32;
  localparam int BEATS_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_GRANT      = 3'd2,
    ST_WAIT_BURST = 3'd3,
    ST_DONE       = 3'd4
  } arb_state_t;

  // Beats for the next burst: whatever is left, capped at the burst limit.
  function automatic logic [BEATS_W-1:0] burst_beats(input logic [SIZE_W-1:0] remaining,
                                                     input int max_beats);
    if (remaining >= SIZE_W'(max_beats)) begin
      return BEATS_W'(max_beats);
    end
    return remaining[BEATS_W-1:0];
  endfunction

endpackage

// File: rtl/channel_arbiter_priority_select.sv
// rtl/channel_arbiter_priority_select.sv - combinational highest-priority pending channel search
module arb_priority_select
  import channel_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEFAULT
) (
  input  logic [NUM_CHANNELS-1:0]             pending,
  input  logic [NUM_CHANNELS-1:0][PRIO_W-1:0] prio,
  output logic [CH_ID_W-1:0]                  winner,
  output logic                                found
);

  logic [PRIO_W-1:0] best_prio;

  // Scan upward; only a strictly larger priority displaces, so ties stay with the lowest ID.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (pending[i] && (!found || (prio[i] > best_prio))) begin
        found     = 1'b1;
        best_prio = prio[i];
        winner    = CH_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/channel_arbiter.sv
// rtl/channel_arbiter.sv - priority channel arbiter issuing bounded bursts with re-arbitration per burst
module channel_arbiter
  import channel_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS    = NUM_CHANNELS_DEFAULT,
  parameter int MAX_BURST_BEATS = MAX_BURST_BEATS_DEFAULT
) (
  input  logic                AXI_aclk,
  input  logic                AXI_areset,
  input  logic                arbSample,
  input  logic [5:0]          arbCurrentChannelSample,
  input  logic [PRIO_W-1:0]   arbChannelPriority,
  input  logic [SIZE_W-1:0]   arbChannelTransferSize,
  input  logic                arbitrate,
  output logic                arbWriteTransactionsDone,
  output logic                grant_valid,
  output logic [CH_ID_W-1:0]  grant_channel,
  output logic [BEATS_W-1:0]  grant_beats,
  input  logic                grant_ready,
  input  logic                burst_done
);

  arb_state_t state;

  // Channel table
  logic [NUM_CHANNELS-1:0]             pending;
  logic [NUM_CHANNELS-1:0][PRIO_W-1:0] prio;
  logic [NUM_CHANNELS-1:0][SIZE_W-1:0] remaining;

  logic [CH_ID_W-1:0] winner;

  logic [CH_ID_W-1:0] sel_id;
  logic               sel_found;

  logic [CH_ID_W-1:0] sample_idx;
  logic               sample_accept;
  logic [SIZE_W-1:0]  winner_remaining;
  logic [SIZE_W-1:0]  granted_beats_w;

  assign sample_idx       = arbCurrentChannelSample[CH_ID_W-1:0];
  assign sample_accept    = arbSample && !arbCurrentChannelSample[5] &&
                            ({{(32-CH_ID_W){1'b0}}, sample_idx} < 32'(NUM_CHANNELS));
  assign winner_remaining = remaining[winner];
  assign granted_beats_w  = {{(SIZE_W-BEATS_W){1'b0}}, grant_beats};

  arb_priority_select #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_select (
    .pending (pending),
    .prio    (prio),
    .winner  (sel_id),
    .found   (sel_found)
  );

  // Arbitration FSM: table loading, winner selection, grant handshake and burst accounting.
  always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
    if (AXI_areset) begin
      state                    <= ST_IDLE;
      pending                  <= '0;
      prio                     <= '0;
      remaining                <= '0;
      winner                   <= '0;
      grant_valid              <= 1'b0;
      grant_channel            <= '0;
      grant_beats              <= '0;
      arbWriteTransactionsDone <= 1'b0;
    end else begin
      arbWriteTransactionsDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_accept) begin
            prio[sample_idx]      <= arbChannelPriority;
            remaining[sample_idx] <= arbChannelTransferSize;
            pending[sample_idx]   <= (arbChannelTransferSize != '0);
          end
          if (arbitrate) begin
            state <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (sel_found) begin
            winner        <= sel_id;
            grant_valid   <= 1'b1;
            grant_channel <= sel_id;
            grant_beats   <= burst_beats(remaining[sel_id], MAX_BURST_BEATS);
            state         <= ST_GRANT;
          end else begin
            arbWriteTransactionsDone <= 1'b1;
            state                    <= ST_DONE;
          end
        end

        ST_GRANT: begin
          if (grant_ready) begin
            grant_valid <= 1'b0;
            state       <= ST_WAIT_BURST;
          end
        end

        ST_WAIT_BURST: begin
          if (burst_done) begin
            remaining[winner] <= winner_remaining - granted_beats_w;
            if (winner_remaining == granted_beats_w) begin
              pending[winner] <= 1'b0;
            end
            state <= ST_SELECT;
          end
        end

        ST_DONE: begin
          pending   <= '0;
          prio      <= '0;
          remaining <= '0;
          winner    <= '0;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
